// File: rtl/vga_tile_render.sv
// vga_tile_render: three-stage pixel renderer behind the 640x480 VGA timing
// generator. Looks up the 16x16 cell under each pixel in a 40x30 tile memory,
// decodes the cell type to RGB332 and delays the syncs to stay aligned with
// the colour. Also emits a one-cycle tick on each vsync falling edge.
module vga_tile_render #(
   parameter logic [7:0] C_BG      = 8'h00,
   parameter logic [7:0] C_BODY    = 8'h1C,
   parameter logic [7:0] C_HEAD    = 8'hFC,
   parameter logic [7:0] C_FOOD    = 8'hE0,
   parameter int         BLINK_BIT = 4
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        vidon,
   input  logic        hsync,
   input  logic        vsync,
   output logic [10:0] tile_addr,
   input  logic [1:0]  tile_data,
   output logic [7:0]  rgb,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        vidon_o,
   output logic        frame_tick
);

   // Per-pixel side information carried alongside the tile lookup
   typedef struct packed {
      logic [3:0] px;
      logic [3:0] py;
      logic       vid;
      logic       hs;
      logic       vs;
   } pix_t;

   localparam pix_t PIX_ZERO = '0;

   pix_t        s1;
   pix_t        s2;
   pix_t        s0;
   logic [4:0]  row;
   logic [5:0]  col;
   logic [10:0] addr_nxt;
   logic [7:0]  colour;
   logic        outline;
   logic        vs_prev;
   logic [7:0]  frame_cnt;
   logic        unused_y9;

   // Only rows 0..29 exist, so y[9] never selects a cell
   assign unused_y9 = y[9];

   assign row = y[8:4];
   assign col = x[9:4];

   // row*40 + col built from shifts; fits in 11 bits for row<=29, col<=39
   assign addr_nxt = {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col};

   assign s0.px  = x[3:0];
   assign s0.py  = y[3:0];
   assign s0.vid = vidon;
   assign s0.hs  = hsync;
   assign s0.vs  = vsync;

   assign outline = (s2.px == 4'd0) || (s2.px == 4'd15) ||
                    (s2.py == 4'd0) || (s2.py == 4'd15);

   // Stage C colour decode; blanking always wins over the tile contents
   always_comb begin
      colour = C_BG;
      if (s2.vid) begin
         case (tile_data)
            2'd1:    colour = C_BODY;
            2'd2:    colour = outline ? 8'h00 : C_HEAD;
            2'd3:    colour = frame_cnt[BLINK_BIT] ? C_BG : C_FOOD;
            default: colour = C_BG;
         endcase
      end
   end

   // Stage A: address generation (zeroed in blanking, where x/y run out of
   // range) and capture of the pixel side information
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         tile_addr <= '0;
         s1        <= PIX_ZERO;
      end else begin
         tile_addr <= vidon ? addr_nxt : 11'd0;
         s1        <= s0;
      end
   end

   // Stage B: side information waits while the tile memory reads
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         s2 <= PIX_ZERO;
      end else begin
         s2 <= s1;
      end
   end

   // Stage C: registered colour and syncs, all aligned to the same pixel
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         rgb     <= '0;
         hsync_o <= 1'b0;
         vsync_o <= 1'b0;
         vidon_o <= 1'b0;
      end else begin
         rgb     <= colour;
         hsync_o <= s2.hs;
         vsync_o <= s2.vs;
         vidon_o <= s2.vid;
      end
   end

   // Frame counter: vsync falling edge bumps the count and pulses the tick.
   // vs_prev resets low so leaving reset with vsync low never ticks.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         vs_prev    <= 1'b0;
         frame_cnt  <= '0;
         frame_tick <= 1'b0;
      end else begin
         vs_prev <= vsync;
         if (vs_prev && !vsync) begin
            frame_cnt  <= frame_cnt + 8'd1;
            frame_tick <= 1'b1;
         end else begin
            frame_tick <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_tile_render.sv
// Directed bench for vga_tile_render with a synchronous tile memory model.
module tb_vga_tile_render;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [9:0]  x, y;
   logic        vidon, hsync, vsync;
   logic [10:0] tile_addr;
   logic [1:0]  tile_data;
   logic [7:0]  rgb;
   logic        hsync_o, vsync_o, vidon_o, frame_tick;

   logic [1:0]  mem [0:1199];
   int          n_chk = 0;
   int          n_fail = 0;

   vga_tile_render dut (
      .clk(clk), .clr_n(clr_n), .x(x), .y(y), .vidon(vidon),
      .hsync(hsync), .vsync(vsync), .tile_addr(tile_addr),
      .tile_data(tile_data), .rgb(rgb), .hsync_o(hsync_o),
      .vsync_o(vsync_o), .vidon_o(vidon_o), .frame_tick(frame_tick)
   );

   always #20 clk = ~clk;

   // Tile memory: one-cycle read latency
   always @(posedge clk) begin
      if (tile_addr < 11'd1200) tile_data <= mem[tile_addr];
      else                      tile_data <= 2'd0;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int px, input int py, input logic v,
                        input logic h, input logic vs);
      x = px[9:0]; y = py[9:0]; vidon = v; hsync = h; vsync = vs;
   endtask

   task automatic test_reset;
      logic [7:0] exp_rgb;
      clr_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               1'($urandom), 1'($urandom), 1'($urandom));
         step();
         n_chk++;
         if (rgb !== 8'h00 || tile_addr !== 11'd0 || hsync_o !== 1'b0 ||
             vsync_o !== 1'b0 || vidon_o !== 1'b0 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: rgb=%h addr=%0d hs=%b vs=%b vid=%b tick=%b, want all 0",
                     i, rgb, tile_addr, hsync_o, vsync_o, vidon_o, frame_tick);
         end
      end
      // release with vsync low: no tick may appear
      clr_n = 1'b1;
      drive(0, 0, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         step();
         drive(0, 0, 1'b1, 1'b1, 1'b1);
         exp_rgb = (i == 3) ? 8'h1C : 8'h00;
         n_chk++;
         if (rgb !== exp_rgb || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release edge%0d: rgb=%h tick=%b, want rgb=%h tick=0",
                     i, rgb, frame_tick, exp_rgb);
         end
      end
      n_chk++;
      if (vidon_o !== 1'b1 || hsync_o !== 1'b1 || vsync_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_sync: vid=%b hs=%b vs=%b, want 1 1 0",
                  vidon_o, hsync_o, vsync_o);
      end
   endtask

   task automatic test_addr_map;
      int         vx [7] = '{0, 16, 639, 0, 639, 200, 1000};
      int         vy [7] = '{0, 0, 0, 16, 479, 100, 5};
      logic       vv [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [10:0] ea [7] = '{11'd0, 11'd1, 11'd39, 11'd40, 11'd1199, 11'd252, 11'd0};
      for (int i = 0; i < 7; i++) begin
         drive(vx[i], vy[i], vv[i], 1'b1, 1'b1);
         step();
         n_chk++;
         if (tile_addr !== ea[i]) begin
            n_fail++;
            $display("FAIL addr_map (%0d,%0d,vid=%b): addr=%0d, want %0d",
                     vx[i], vy[i], vv[i], tile_addr, ea[i]);
         end
      end
   endtask

   task automatic test_colour_decode;
      logic [7:0] exp_rgb;
      int         p;
      for (int i = 0; i < 66; i++) begin
         drive((i < 64) ? i : 63, 5, 1'b1, 1'b1, 1'b1);
         step();
         if (i >= 2) begin
            p = i - 2;
            case (p / 16)
               0:       exp_rgb = 8'h1C;
               1:       exp_rgb = ((p % 16) == 0 || (p % 16) == 15) ? 8'h00 : 8'hFC;
               2:       exp_rgb = 8'hE0;
               default: exp_rgb = 8'h00;
            endcase
            n_chk++;
            if (rgb !== exp_rgb) begin
               n_fail++;
               $display("FAIL colour_stream x=%0d: rgb=%h, want %h", p, rgb, exp_rgb);
            end
         end
      end
   endtask

   task automatic test_head_outline;
      int         hy [3] = '{15, 14, 0};
      int         hx [3] = '{20, 20, 24};
      logic [7:0] er [3] = '{8'h00, 8'hFC, 8'h00};
      for (int i = 0; i < 3; i++) begin
         drive(hx[i], hy[i], 1'b1, 1'b1, 1'b1);
         step(); step(); step();
         n_chk++;
         if (rgb !== er[i]) begin
            n_fail++;
            $display("FAIL head_outline (%0d,%0d): rgb=%h, want %h",
                     hx[i], hy[i], rgb, er[i]);
         end
      end
   endtask

   task automatic test_align;
      logic [31:0] pv = 32'hA5C3_96F1;
      logic [31:0] ph = 32'h3C5A_E18D;
      logic [31:0] ps = 32'hF00F_6699;
      for (int i = 0; i < 34; i++) begin
         if (i < 32) drive(0, 0, pv[i], ph[i], ps[i]);
         step();
         if (i >= 2) begin
            n_chk++;
            if (vidon_o !== pv[i-2] || hsync_o !== ph[i-2] || vsync_o !== ps[i-2] ||
                rgb !== (pv[i-2] ? 8'h1C : 8'h00)) begin
               n_fail++;
               $display("FAIL align cyc%0d: vid=%b hs=%b vs=%b rgb=%h, want %b %b %b %h",
                        i, vidon_o, hsync_o, vsync_o, rgb, pv[i-2], ph[i-2], ps[i-2],
                        pv[i-2] ? 8'h1C : 8'h00);
            end
         end
      end
   endtask

   task automatic do_reset;
      clr_n = 1'b0;
      drive(0, 0, 1'b0, 1'b1, 1'b1);
      step(); step();
      clr_n = 1'b1;
   endtask

   // Compressed frames: food pixel drawn, blanking, 2-cycle vsync pulse
   task automatic test_frames;
      int         ticks = 0;
      logic [7:0] exp_food;
      logic       exp_tick;
      do_reset();
      for (int f = 0; f < 40; f++) begin
         exp_food = (f < 16 || f >= 32) ? 8'hE0 : 8'h00;
         for (int s = 0; s < 10; s++) begin
            if (s < 4)      drive(32, 5, 1'b1, 1'b1, 1'b1);
            else if (s < 6) drive(0, 0, 1'b0, 1'b1, 1'b1);
            else if (s < 8) drive(0, 0, 1'b0, 1'b1, 1'b0);
            else            drive(0, 0, 1'b0, 1'b1, 1'b1);
            step();
            exp_tick = (s == 6);
            if (frame_tick === 1'b1) ticks++;
            n_chk++;
            if (frame_tick !== exp_tick) begin
               n_fail++;
               $display("FAIL frame_tick f%0d s%0d: tick=%b, want %b",
                        f, s, frame_tick, exp_tick);
            end
            if (s == 2 || s == 3) begin
               n_chk++;
               if (rgb !== exp_food) begin
                  n_fail++;
                  $display("FAIL blink frame%0d: rgb=%h, want %h", f, rgb, exp_food);
               end
            end
         end
      end
      n_chk++;
      if (ticks != 40) begin
         n_fail++;
         $display("FAIL tick_count: got %0d, want 40", ticks);
      end
   endtask

   task automatic test_mid_reset;
      logic [7:0] exp_rgb;
      // frame count 40 -> 48 so the food is in its hidden phase
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 1'b0, 1'b1, 1'b0); step();
         drive(0, 0, 1'b0, 1'b1, 1'b1); step();
      end
      drive(300, 200, 1'b1, 1'b1, 1'b1);
      step(); step(); step();
      n_chk++;
      if (rgb !== 8'h00 || tile_addr !== 11'd498 || vidon_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre: rgb=%h addr=%0d vid=%b, want 00 498 1",
                  rgb, tile_addr, vidon_o);
      end
      clr_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++;
         if (rgb !== 8'h00 || tile_addr !== 11'd0 || hsync_o !== 1'b0 ||
             vsync_o !== 1'b0 || vidon_o !== 1'b0 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset cyc%0d: rgb=%h addr=%0d hs=%b vs=%b vid=%b tick=%b, want all 0",
                     i, rgb, tile_addr, hsync_o, vsync_o, vidon_o, frame_tick);
         end
      end
      clr_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         exp_rgb = (i >= 3) ? 8'hE0 : 8'h00;
         n_chk++;
         if (rgb !== exp_rgb || frame_tick !== 1'b0 || vidon_o !== (i >= 3)) begin
            n_fail++;
            $display("FAIL mid_recover edge%0d: rgb=%h tick=%b vid=%b, want %h 0 %b",
                     i, rgb, frame_tick, vidon_o, exp_rgb, (i >= 3));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1200; i++) mem[i] = 2'd0;
      mem[0] = 2'd1; mem[1] = 2'd2; mem[2] = 2'd3; mem[3] = 2'd0;
      mem[498] = 2'd3;
      clr_n = 1'b0;
      drive(0, 0, 1'b0, 1'b1, 1'b1);
      test_reset();
      test_addr_map();
      test_colour_decode();
      test_head_outline();
      test_align();
      test_frames();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
